// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: nop encoding and default datapath widths.
package fetch_queue_pkg;

    localparam int PC_W_DEFAULT    = 32;
    localparam int INSTR_W_DEFAULT = 32;

    // addi x0, x0, 0 -- decode uses it as the reset-value mask.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [63:0] pack_entry(input logic [31:0] instr, input logic [31:0] pc);
        return {instr, pc};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo_ram.sv
// Register array for fetch_queue entries: one write port, one asynchronous read port.
module fifo_ram #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Cleared on reset so the head outputs read as zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with valid/ready on both sides and flush.
// Optional combinational empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = INSTR_W + PC_W;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          empty;
    logic          push, pop;
    logic          wr_en, rd_adv;
    logic [EW-1:0] head;

    fifo_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && !flush),
        .waddr (wr_ptr_q),
        .wdata ({in_instr, in_pc}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        empty    = (count_q == '0);
        in_ready = (count_q != CW'(DEPTH));
        out_valid = !empty;
        out_instr = head[EW-1:PC_W];
        out_pc    = head[PC_W-1:0];
`ifdef FETCH_QUEUE_BYPASS_EN
        if (empty && !flush) begin
            out_valid = in_valid;
            out_instr = in_instr;
            out_pc    = in_pc;
        end
`endif
        push   = in_valid && in_ready;
        pop    = out_valid && out_ready;
        wr_en  = push;
        rd_adv = pop;
`ifdef FETCH_QUEUE_BYPASS_EN
        // A pop while empty is a bypassed hand-over: nothing is stored.
        if (empty && pop) begin
            wr_en  = 1'b0;
            rd_adv = 1'b0;
        end
`endif
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_adv})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue with a scoreboard of accepted words.
module tb_fetch_queue;

    localparam int DEPTH   = 2;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr = '0;
    logic [PC_W-1:0]    in_pc = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [CW-1:0]      count;

    int checks = 0;
    int errors = 0;
    logic [INSTR_W+PC_W-1:0] sb [$];

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Scoreboard: record accepted words, compare every consumed head.
    always @(negedge clk) begin
        logic [INSTR_W+PC_W-1:0] exp;
        if (!reset || flush) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back({in_instr, in_pc});
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: got %h/%h, expected no word", out_instr, out_pc);
                end else begin
                    exp = sb.pop_front();
                    if ({out_instr, out_pc} !== exp) begin
                        errors++;
                        $display("FAIL sb_order: got %h/%h, expected %h/%h",
                                 out_instr, out_pc, exp[63:32], exp[31:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1 ||
            out_instr !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL reset_state: ov=%b cnt=%0d ir=%b instr=%h pc=%h, expected 0/0/1/0/0",
                     out_valid, count, in_ready, out_instr, out_pc);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h0;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h13 || out_pc !== 32'h0 || count !== CW'(1)) begin
            errors++;
            $display("FAIL single_push: ov=%b instr=%h pc=%h cnt=%0d, expected 1/00000013/0/1",
                     out_valid, out_instr, out_pc, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: cnt=%0d ov=%b, expected 0/0", count, out_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_i [3];
        logic [31:0] exp_p [3];
        exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33;
        exp_p[0] = 32'h0;  exp_p[1] = 32'h4;  exp_p[2] = 32'h8;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h11; in_pc = 32'h0;
        step();
        in_instr = 32'h22; in_pc = 32'h4;
        step();
        in_instr = 32'h33; in_pc = 32'h8;
        checks++;
        if (count !== CW'(2) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: cnt=%0d ir=%b, expected 2/0", count, in_ready);
        end
        step();
        checks++;
        if (count !== CW'(2) || out_instr !== 32'h11) begin
            errors++;
            $display("FAIL stall_third_push: cnt=%0d head=%h, expected 2/11", count, out_instr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_i[i] || out_pc !== exp_p[i]) begin
                errors++;
                $display("FAIL stall_order%0d: ov=%b instr=%h pc=%h, expected 1/%h/%h",
                         i, out_valid, out_instr, out_pc, exp_i[i], exp_p[i]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drained: cnt=%0d pending=%0d, expected 0/0", count, sb.size());
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            in_valid = (k < 8);
            in_instr = 32'h100 + k;
            in_pc    = 32'(4 * k);
            checks++;
            if (k == 0 || k == 9) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_edge%0d: ov=%b, expected 0", k, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_instr !== 32'h100 + k - 1 ||
                         out_pc !== 32'(4 * (k - 1)) || count !== CW'(1)) begin
                errors++;
                $display("FAIL stream_word%0d: ov=%b instr=%h pc=%h cnt=%0d, expected 1/%h/%h/1",
                         k, out_valid, out_instr, out_pc, count, 32'h100 + k - 1, 4 * (k - 1));
            end
            step();
        end
        idle();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 32'hA0; in_pc = 32'h10;
        step();
        in_instr = 32'hA1; in_pc = 32'h14;
        step();
        checks++;
        if (count !== CW'(2)) begin
            errors++;
            $display("FAIL flush_fill: cnt=%0d, expected 2", count);
        end
        flush = 1'b1; in_instr = 32'h44; in_pc = 32'h100;
        step();
        flush = 1'b0;
        in_instr = 32'h55; in_pc = 32'h200;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: cnt=%0d ov=%b ir=%b, expected 0/0/1", count, out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h55 || out_pc !== 32'h200 || count !== CW'(1)) begin
            errors++;
            $display("FAIL flush_repush: ov=%b instr=%h pc=%h cnt=%0d, expected 1/55/200/1",
                     out_valid, out_instr, out_pc, count);
        end
        // Flush with a legal push and pop pending: both must be dropped.
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h44; in_pc = 32'h100;
        step();
        idle();
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_push_ignored: cnt=%0d ov=%b, expected 0/0", count, out_valid);
        end
        step();
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stays_empty: cnt=%0d ov=%b, expected 0/0", count, out_valid);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_instr = 32'h66; in_pc = 32'h300;
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== CW'(1)) begin
            errors++;
            $display("FAIL areset_pre: cnt=%0d, expected 1", count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_now: ov=%b cnt=%0d ir=%b, expected 0/0/1", out_valid, count, in_ready);
        end
        step();
        reset = 1'b1;
        step();
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        in_valid = 1'b1; in_instr = 32'h55; in_pc = 32'h20; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h55 || out_pc !== 32'h20) begin
            errors++;
            $display("FAIL bypass_same_cycle: ov=%b instr=%h pc=%h, expected 1/55/20",
                     out_valid, out_instr, out_pc);
        end
        step();
        idle();
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_count: cnt=%0d ov=%b, expected 0/0", count, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_stream();
        test_flush();
        test_async_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
